// File: rtl/compl_decoder_pkg.sv
// Shared definitions for the complement datapath: FSM state encodings and
// the one's/two's-complement select constants.
package compl_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic CPL_ONES = 1'b1;
    localparam logic CPL_TWOS = 1'b0;

endpackage

// File: rtl/compl_bit_cell.sv
// Combinational per-bit stage of the serial sign/magnitude decoder.
module compl_bit_cell
    import compl_decoder_pkg::*;
(
    input  logic b,
    input  logic sgn,
    input  logic cpl,
    input  logic seen1,
    output logic out,
    output logic seen1_next
);

    // Two's-complement negation copies up to and including the first 1, then inverts.
    always_comb begin
        out = b;
        if (sgn) begin
            if (cpl == CPL_ONES) begin
                out = ~b;
            end else begin
                out = seen1 ? ~b : b;
            end
        end
        seen1_next = seen1 | b;
    end

endmodule

// File: rtl/compl_decoder.sv
// Bit-serial decoder: signed one's/two's-complement operand to sign + unsigned
// magnitude, LSB first, one bit per clock under a start/done handshake.
module compl_decoder
    import compl_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Ent,
    input  logic             cpl,
    output logic [WIDTH-1:0] Mag,
    output logic             Sgn,
    output logic             negzero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seen1_q, seen1_d;
    logic               cpl_q, cpl_d;
    logic               sgn_r_q, sgn_r_d;
    logic               ones_q, ones_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic               sgn_q, sgn_d;
    logic               negzero_q, negzero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cell_out;
    logic               cell_seen1;

    compl_bit_cell u_cell (
        .b          (shreg_q[0]),
        .sgn        (sgn_r_q),
        .cpl        (cpl_q),
        .seen1      (seen1_q),
        .out        (cell_out),
        .seen1_next (cell_seen1)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        seen1_d   = seen1_q;
        cpl_d     = cpl_q;
        sgn_r_d   = sgn_r_q;
        ones_d    = ones_q;
        mag_d     = mag_q;
        sgn_d     = sgn_q;
        negzero_d = negzero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    shreg_d  = Ent;
                    cpl_d    = cpl;
                    sgn_r_d  = Ent[WIDTH-1];
                    ones_d   = &Ent;
                    cnt_d    = '0;
                    seen1_d  = 1'b0;
                    result_d = '0;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
                result_d = {cell_out, result_q[WIDTH-1:1]};
                seen1_d  = cell_seen1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Final bit: publish the whole result at once so no partial value is visible.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    mag_d     = result_d;
                    sgn_d     = sgn_r_q;
                    negzero_d = (cpl_q == CPL_ONES) & ones_q;
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            seen1_q   <= 1'b0;
            cpl_q     <= 1'b0;
            sgn_r_q   <= 1'b0;
            ones_q    <= 1'b0;
            mag_q     <= '0;
            sgn_q     <= 1'b0;
            negzero_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            seen1_q   <= seen1_d;
            cpl_q     <= cpl_d;
            sgn_r_q   <= sgn_r_d;
            ones_q    <= ones_d;
            mag_q     <= mag_d;
            sgn_q     <= sgn_d;
            negzero_q <= negzero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Mag     = mag_q;
    assign Sgn     = sgn_q;
    assign negzero = negzero_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_compl_decoder.sv
// Scoreboard bench for compl_decoder: stimulus queues expected {Mag,Sgn,negzero},
// a monitor pops and compares on every done pulse.
module tb_compl_decoder;
    import compl_decoder_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] Ent;
    logic       cpl;
    logic [3:0] Mag;
    logic       Sgn;
    logic       negzero;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    logic [5:0] exp_q[$];

    compl_decoder #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .Ent     (Ent),
        .cpl     (cpl),
        .Mag     (Mag),
        .Sgn     (Sgn),
        .negzero (negzero),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (!reset && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got Mag=%0h Sgn=%0b nz=%0b want no done", Mag, Sgn, negzero);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'({Mag, Sgn, negzero}), 32'(e));
                end
            end
        end
    end

    task automatic run_one(input logic [3:0] ent, input logic c, input logic [3:0] em,
                           input logic es, input logic enz, input bit poke);
        int bsy;
        int cyc;
        @(negedge clk);
        start = 1'b1;
        Ent   = ent;
        cpl   = c;
        exp_q.push_back({em, es, enz});
        @(negedge clk);
        start = 1'b0;
        Ent   = ~ent;
        cpl   = ~c;
        bsy   = 0;
        cyc   = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy === 1'b1) bsy++;
            start = poke && (cyc == 1);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'(1));
        check("busy_cycles", 32'(bsy), 32'(4));
        @(negedge clk);
        check("done_one_cycle", 32'({done, busy}), 32'(0));
        check("result_hold", 32'({Mag, Sgn, negzero}), 32'({em, es, enz}));
    endtask

    initial begin
        logic [3:0] bv[3];
        logic [5:0] bx[3];
        bv = '{4'b1101, 4'b0110, 4'b1000};
        bx = '{{4'b0011, 1'b1, 1'b0}, {4'b0110, 1'b0, 1'b0}, {4'b1000, 1'b1, 1'b0}};

        reset = 1'b1;
        start = 1'b0;
        Ent   = '0;
        cpl   = CPL_TWOS;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_idle", 32'({Mag, Sgn, negzero, busy, done}), 32'(0));
        end

        run_one(4'b1101, CPL_TWOS, 4'b0011, 1'b1, 1'b0, 1'b0);
        run_one(4'b1000, CPL_TWOS, 4'b1000, 1'b1, 1'b0, 1'b0);
        run_one(4'b1111, CPL_ONES, 4'b0000, 1'b1, 1'b1, 1'b0);
        run_one(4'b1010, CPL_ONES, 4'b0101, 1'b1, 1'b0, 1'b0);
        run_one(4'b0110, CPL_TWOS, 4'b0110, 1'b0, 1'b0, 1'b0);
        run_one(4'b0110, CPL_ONES, 4'b0110, 1'b0, 1'b0, 1'b0);
        run_one(4'b0000, CPL_ONES, 4'b0000, 1'b0, 1'b0, 1'b0);
        run_one(4'b0000, CPL_TWOS, 4'b0000, 1'b0, 1'b0, 1'b0);
        run_one(4'b1111, CPL_TWOS, 4'b0001, 1'b1, 1'b0, 1'b0);
        run_one(4'b1001, CPL_ONES, 4'b0110, 1'b1, 1'b0, 1'b1);

        // Back-to-back with start held high; Ent scrambled while shifting.
        @(negedge clk);
        start = 1'b1;
        cpl   = CPL_TWOS;
        Ent   = bv[0];
        exp_q.push_back(bx[0]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            Ent = ~bv[k];
            repeat (4) @(negedge clk);
            check("b2b_period", 32'(done), 32'(1));
            if (k < 2) begin
                Ent = bv[k+1];
                exp_q.push_back(bx[k+1]);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle", 32'({done, busy}), 32'(0));

        // Reset two cycles into a conversion.
        @(negedge clk);
        start = 1'b1;
        Ent   = 4'b1101;
        cpl   = CPL_TWOS;
        exp_q.push_back({4'b0011, 1'b1, 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("reset_midop", 32'({Mag, Sgn, negzero, busy, done}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_quiet", 32'({Mag, Sgn, negzero, busy, done}), 32'(0));
        end
        run_one(4'b0011, CPL_TWOS, 4'b0011, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
